// File: rtl/ir_blob_decoder.sv
// rtl/ir_blob_decoder.sv - IR camera extended-mode frame decoder, first valid blob to x/y
module ir_blob_decoder #(
  parameter int MIRROR_X  = 0,
  parameter int MIRROR_Y  = 0,
  parameter int NUM_BLOBS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data,
  input  logic        data_valid,
  input  logic        sof,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [3:0]  size,
  output logic        blob_present,
  output logic        xy_valid,
  output logic        frame_error
);

  localparam int IW = (NUM_BLOBS > 1) ? $clog2(NUM_BLOBS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BLOBS - 1);

  typedef enum logic [2:0] {IDLE, XL, YL, HI, DONE} state_t;

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic          found_q;
  logic [7:0]    xl_q, yl_q;
  logic [9:0]    fx_q, fy_q;
  logic [3:0]    fs_q;
  logic [9:0]    x_q, y_q;
  logic [3:0]    size_q;
  logic          present_q, xy_valid_q, frame_error_q;

  logic [9:0] cur_x, cur_y, blob_x_d, blob_y_d;
  logic [3:0] blob_s_d;
  logic       cur_valid, take_d;

  function automatic logic [9:0] mirror(input logic [9:0] v, input int en);
    return (en != 0) ? (10'd1023 - v) : v;
  endfunction

  // The high byte completes the blob; an already-latched blob wins over it.
  assign cur_x     = {data[5:4], xl_q};
  assign cur_y     = {data[7:6], yl_q};
  assign cur_valid = !((cur_x == 10'h3FF) && (cur_y == 10'h3FF));
  assign take_d    = found_q | cur_valid;
  assign blob_x_d  = found_q ? fx_q : cur_x;
  assign blob_y_d  = found_q ? fy_q : cur_y;
  assign blob_s_d  = found_q ? fs_q : data[3:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      found_q       <= 1'b0;
      xl_q          <= '0;
      yl_q          <= '0;
      fx_q          <= '0;
      fy_q          <= '0;
      fs_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      size_q        <= '0;
      present_q     <= 1'b0;
      xy_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      xy_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      if (data_valid && sof) begin
        // A header restarts the frame; mid-frame it also flags the abort.
        if (state_q == XL || state_q == YL || state_q == HI) frame_error_q <= 1'b1;
        state_q <= XL;
        idx_q   <= '0;
        found_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: state_q <= IDLE;
          DONE: state_q <= IDLE;
          XL: if (data_valid) begin
            xl_q    <= data;
            state_q <= YL;
          end
          YL: if (data_valid) begin
            yl_q    <= data;
            state_q <= HI;
          end
          HI: if (data_valid) begin
            if (!found_q && cur_valid) begin
              found_q <= 1'b1;
              fx_q    <= cur_x;
              fy_q    <= cur_y;
              fs_q    <= data[3:0];
            end
            if (idx_q == LAST_IDX) begin
              state_q    <= DONE;
              xy_valid_q <= 1'b1;
              present_q  <= take_d;
              if (take_d) begin
                x_q    <= mirror(blob_x_d, MIRROR_X);
                y_q    <= mirror(blob_y_d, MIRROR_Y);
                size_q <= blob_s_d;
              end
            end else begin
              idx_q   <= idx_q + IW'(1);
              state_q <= XL;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign x            = {1'b0, x_q};
  assign y            = {1'b0, y_q};
  assign size         = size_q;
  assign blob_present = present_q;
  assign xy_valid     = xy_valid_q;
  assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_ir_blob_decoder.sv
// tb/tb_ir_blob_decoder.sv - self-checking bench for ir_blob_decoder (plain and X-mirrored)
module tb_ir_blob_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data;
  logic        data_valid, sof;
  logic [10:0] x, y, mx, my;
  logic [3:0]  size, msize;
  logic        blob_present, xy_valid, frame_error;
  logic        mblob_present, mxy_valid, mframe_error;

  always #5 clk = ~clk;

  ir_blob_decoder dut (
    .clk(clk), .reset(reset), .data(data), .data_valid(data_valid), .sof(sof),
    .x(x), .y(y), .size(size), .blob_present(blob_present),
    .xy_valid(xy_valid), .frame_error(frame_error)
  );

  ir_blob_decoder #(.MIRROR_X(1)) dut_m (
    .clk(clk), .reset(reset), .data(data), .data_valid(data_valid), .sof(sof),
    .x(mx), .y(my), .size(msize), .blob_present(mblob_present),
    .xy_valid(mxy_valid), .frame_error(mframe_error)
  );

  typedef logic [12:0][7:0] frame_t;
  typedef struct {
    frame_t b;
    int     gap;
    int     ex, ey, es, ep, emx;
  } vec_t;
  typedef struct { int x, y, s, p, mx; } exp_t;

  vec_t vecs[6];
  exp_t sbq[$];
  int   n_checks = 0, n_fail = 0;
  int   xy_cnt = 0, fe_cnt = 0, mfe_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic frame_t frame1(input int k, input logic [7:0] b0, b1, b2);
    frame_t f;
    for (int i = 0; i < 13; i++) f[i] = 8'hFF;
    f[0] = 8'h00;
    f[1+3*k] = b0;
    f[2+3*k] = b1;
    f[3+3*k] = b2;
    return f;
  endfunction

  function automatic exp_t mk(input int ex, ey, es, ep, emx);
    exp_t e;
    e.x = ex; e.y = ey; e.s = es; e.p = ep; e.mx = emx;
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic s, input int gap);
    for (int g = 0; g < gap; g++) begin
      data_valid = 1'b0;
      @(posedge clk); #1;
    end
    data = b; data_valid = 1'b1; sof = s;
    @(posedge clk); #1;
    data_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input int gap, input exp_t e);
    sbq.push_back(e);
    for (int i = 0; i < 13; i++) send_byte(f[i], i == 0, gap);
    chk("latency", xy_valid, 1);
  endtask

  // Scoreboard: each xy_valid pulse retires the oldest expected frame.
  always @(negedge clk) begin
    if (frame_error) fe_cnt++;
    if (mframe_error) mfe_cnt++;
    if (xy_valid || mxy_valid) begin
      exp_t e;
      xy_cnt++;
      chk("xy_valid_pair", mxy_valid, xy_valid);
      if (sbq.size() == 0) begin
        chk("unexpected_xy_valid", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("x", x, e.x);
        chk("y", y, e.y);
        chk("size", size, e.s);
        chk("blob_present", blob_present, e.p);
        chk("mirror_x", mx, e.mx);
        chk("mirror_y", my, e.y);
        chk("mirror_present", mblob_present, e.p);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d expected frames pending", sbq.size());
    $fatal(1);
  end

  initial begin
    frame_t sel;
    int fe0;
    sel = frame1(1, 8'h0A, 8'h14, 8'h00);
    sel[7] = 8'h64; sel[8] = 8'h64; sel[9] = 8'h00;
    vecs[0] = '{frame1(0, 8'hF4, 8'h2C, 8'h53), 0, 500, 300, 3, 1, 523};
    vecs[1] = '{frame1(0, 8'hFF, 8'hFF, 8'hFF), 0, 500, 300, 3, 0, 523};
    vecs[2] = '{sel,                            0, 10, 20, 0, 1, 1013};
    vecs[3] = '{frame1(0, 8'hF4, 8'h2C, 8'h53), 3, 500, 300, 3, 1, 523};
    vecs[4] = '{frame1(3, 8'h01, 8'h02, 8'hF7), 0, 769, 770, 7, 1, 254};
    vecs[5] = '{frame1(0, 8'hFF, 8'hFF, 8'h35), 0, 1023, 255, 5, 1, 0};

    reset = 1'b1; data = 8'h00; data_valid = 1'b0; sof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_size", size, 0);
    chk("rst_present", blob_present, 0);
    chk("rst_xy_valid", xy_valid, 0);
    chk("rst_frame_error", frame_error, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    send_byte(8'h55, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].b, vecs[i].gap,
                 mk(vecs[i].ex, vecs[i].ey, vecs[i].es, vecs[i].ep, vecs[i].emx));
      repeat (2) @(posedge clk);
      #1;
    end

    // Abort: a header arrives as byte 5 and becomes the start of the next frame.
    fe0 = fe_cnt;
    send_byte(8'h00, 1'b1, 0);
    for (int i = 0; i < 4; i++) send_byte(8'hFF, 1'b0, 0);
    send_frame(frame1(0, 8'h0A, 8'h14, 8'h00), 0, mk(10, 20, 0, 1, 1013));
    @(posedge clk); #1;
    chk("abort_frame_error_cnt", fe_cnt, fe0 + 1);
    chk("abort_mirror_fe_cnt", mfe_cnt, fe0 + 1);
    chk("abort_xy_cnt", xy_cnt, 7);

    // Reset asserted between clock edges clears outputs without waiting for clk.
    send_frame(frame1(0, 8'hF4, 8'h2C, 8'h53), 0, mk(500, 300, 3, 1, 523));
    @(posedge clk); #1;
    send_byte(8'h00, 1'b1, 0);
    for (int i = 0; i < 3; i++) send_byte(8'h11, 1'b0, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_x", x, 0);
    chk("async_rst_y", y, 0);
    chk("async_rst_size", size, 0);
    chk("async_rst_present", blob_present, 0);
    chk("async_rst_mx", mx, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send_frame(frame1(0, 8'hF4, 8'h2C, 8'h53), 0, mk(500, 300, 3, 1, 523));

    // Header immediately in DONE: previous frame completes, new one starts, no error.
    fe0 = fe_cnt;
    send_frame(frame1(2, 8'h0A, 8'h14, 8'h00), 0, mk(10, 20, 0, 1, 1013));
    send_frame(frame1(0, 8'hF4, 8'h2C, 8'h53), 0, mk(500, 300, 3, 1, 523));
    repeat (3) @(posedge clk);
    #1;
    chk("done_sof_no_error", fe_cnt, fe0);
    chk("total_xy_pulses", xy_cnt, 11);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
